// File: rtl/drone_pkg.sv
// drone_pkg: state codes shared by the drone control unit and the HEX debug decoder
package drone_pkg;
  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    PREPARA    = 4'd1,
    ESPERA     = 4'd2,
    DESLOCA    = 4'd3,
    AGUARDA    = 4'd4,
    VERIFICA   = 4'd5,
    PERDE_VIDA = 4'd8,
    VITORIA    = 4'd14,
    DERROTA    = 4'd15
  } estado_t;
  localparam logic [1:0] POS_VERT_INICIAL = 2'b10;
endpackage

// File: rtl/unidade_controle_drone.sv
// unidade_controle_drone: Moore FSM sequencing the drone game datapath; VIDAS_EN adds a life counter
module unidade_controle_drone #(
  parameter int NUM_VIDAS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       colisao,
  input  logic       fim_espera,
  input  logic       fim_mapa,
  output logic       zeraPosicoes,
  output logic       zeraT,
  output logic       contaT,
  output logic       desloca,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic [3:0] db_estado,
  output logic [1:0] db_vidas
);
  import drone_pkg::*;
  estado_t estado, prox;
`ifdef VIDAS_EN
  localparam estado_t FALHA = PERDE_VIDA;
  logic [1:0] vidas;
  always_ff @(posedge clock)
    if (reset || estado == PREPARA) vidas <= 2'(NUM_VIDAS);
    else if (estado == PERDE_VIDA) vidas <= vidas - 2'd1;
  assign db_vidas = vidas;
`else
  localparam estado_t FALHA = DERROTA;
  logic unused_num_vidas;
  assign unused_num_vidas = ^NUM_VIDAS;
  assign db_vidas = 2'd0;
`endif
  always_ff @(posedge clock) estado <= reset ? INICIAL : prox;
  // collision is checked before end-of-map so a crash on the last column is a loss
  always_comb begin
    prox = INICIAL;
    case (estado)
      INICIAL:          prox = iniciar ? PREPARA : INICIAL;
      PREPARA:          prox = ESPERA;
      ESPERA:           prox = fim_espera ? DESLOCA : ESPERA;
      DESLOCA:          prox = AGUARDA;
      AGUARDA:          prox = VERIFICA;
      VERIFICA:         prox = colisao ? FALHA : fim_mapa ? VITORIA : ESPERA;
`ifdef VIDAS_EN
      PERDE_VIDA:       prox = (vidas == 2'd1) ? DERROTA : ESPERA;
`endif
      VITORIA, DERROTA: prox = iniciar ? PREPARA : estado;
      default:          prox = INICIAL;
    endcase
  end
  assign zeraPosicoes = estado == PREPARA;
  assign zeraT        = estado == PREPARA || estado == DESLOCA || estado == PERDE_VIDA;
  assign contaT       = estado == ESPERA;
  assign desloca      = estado == DESLOCA;
  assign pronto       = estado == VITORIA || estado == DERROTA;
  assign ganhou       = estado == VITORIA;
  assign perdeu       = estado == DERROTA;
  assign db_estado    = estado;
endmodule

// File: tb/tb_unidade_controle_drone.sv
// tb_unidade_controle_drone: table-driven and scoreboarded check of the drone control FSM
module tb_unidade_controle_drone;
  import drone_pkg::*;
  logic clock = 0, reset = 0, iniciar = 0, colisao = 0, fim_espera = 0, fim_mapa = 0;
  logic zeraPosicoes, zeraT, contaT, desloca, pronto, ganhou, perdeu;
  logic [3:0] db_estado;
  logic [1:0] db_vidas;
`ifdef VIDAS_EN
  localparam logic [1:0] VN = 2'd3;
`else
  localparam logic [1:0] VN = 2'd0;
`endif
  typedef struct {logic r, i, c, fe, fm; estado_t st;} vec_t;
  typedef struct {estado_t st; logic [1:0] v; int n;} exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  exp_t e;
  int n_run = 0, n_fail = 0, n_cyc = 0;
  unidade_controle_drone #(.NUM_VIDAS(3)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .colisao(colisao),
    .fim_espera(fim_espera), .fim_mapa(fim_mapa), .zeraPosicoes(zeraPosicoes),
    .zeraT(zeraT), .contaT(contaT), .desloca(desloca), .pronto(pronto),
    .ganhou(ganhou), .perdeu(perdeu), .db_estado(db_estado), .db_vidas(db_vidas)
  );
  always #5 clock = ~clock;
  function automatic logic [6:0] exp_out(estado_t s);
    return {s == PREPARA, s == PREPARA || s == DESLOCA || s == PERDE_VIDA, s == ESPERA,
            s == DESLOCA, s == VITORIA || s == DERROTA, s == VITORIA, s == DERROTA};
  endfunction
  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_run += 3;
      if (db_estado !== e.st) begin
        n_fail++;
        $display("FAIL estado cyc%0d: got %0d want %0d", e.n, db_estado, e.st);
      end
      if ({zeraPosicoes, zeraT, contaT, desloca, pronto, ganhou, perdeu} !== exp_out(e.st)) begin
        n_fail++;
        $display("FAIL strobes cyc%0d: got %b want %b", e.n,
                 {zeraPosicoes, zeraT, contaT, desloca, pronto, ganhou, perdeu}, exp_out(e.st));
      end
      if (db_vidas !== e.v) begin
        n_fail++;
        $display("FAIL vidas cyc%0d: got %0d want %0d", e.n, db_vidas, e.v);
      end
    end
  end
  task automatic cyc(input logic r, i, c, fe, fm, input estado_t st, input logic [1:0] v);
    {reset, iniciar, colisao, fim_espera, fim_mapa} = {r, i, c, fe, fm};
    sb.push_back('{st, v, n_cyc++});
    @(posedge clock);
    #2;
  endtask
  task automatic move(input logic c, fm, input estado_t nxt, input logic [1:0] v);
    cyc(0, 0, 0, 0, 0, ESPERA, v);
    cyc(0, 0, 0, 1, 0, DESLOCA, v);
    cyc(0, 0, 1, 1, 1, AGUARDA, v);
    cyc(0, 1, 1, 0, 1, VERIFICA, v);
    cyc(0, 0, c, 0, fm, nxt, v);
  endtask
  initial begin
    @(posedge clock);
    #2;
    tbl.push_back('{1, 0, 0, 0, 0, INICIAL});
    tbl.push_back('{1, 1, 1, 1, 1, INICIAL});
    tbl.push_back('{0, 0, 0, 1, 0, INICIAL});
    tbl.push_back('{0, 1, 0, 0, 0, PREPARA});
    tbl.push_back('{0, 0, 0, 0, 0, ESPERA});
    tbl.push_back('{0, 1, 0, 0, 0, ESPERA});
    tbl.push_back('{0, 0, 0, 1, 0, DESLOCA});
    tbl.push_back('{0, 0, 0, 1, 0, AGUARDA});
    tbl.push_back('{0, 0, 0, 0, 0, VERIFICA});
    tbl.push_back('{0, 0, 0, 0, 0, ESPERA});
    tbl.push_back('{0, 0, 0, 0, 0, ESPERA});
    tbl.push_back('{0, 0, 0, 1, 0, DESLOCA});
    tbl.push_back('{0, 0, 0, 0, 0, AGUARDA});
    tbl.push_back('{0, 0, 0, 0, 0, VERIFICA});
`ifndef VIDAS_EN
    tbl.push_back('{0, 0, 1, 0, 1, DERROTA});
    tbl.push_back('{0, 0, 0, 1, 0, DERROTA});
    tbl.push_back('{0, 1, 0, 0, 0, PREPARA});
`else
    tbl.push_back('{0, 0, 0, 0, 0, ESPERA});
`endif
    tbl.push_back('{0, 0, 0, 0, 0, ESPERA});
    tbl.push_back('{0, 0, 0, 1, 0, DESLOCA});
    tbl.push_back('{0, 0, 0, 0, 0, AGUARDA});
    tbl.push_back('{1, 1, 0, 0, 0, INICIAL});
    tbl.push_back('{1, 1, 0, 0, 0, INICIAL});
    tbl.push_back('{0, 0, 0, 0, 0, INICIAL});
    foreach (tbl[k]) cyc(tbl[k].r, tbl[k].i, tbl[k].c, tbl[k].fe, tbl[k].fm, tbl[k].st, VN);
    cyc(1, 0, 0, 0, 0, INICIAL, VN);
    cyc(0, 1, 0, 0, 0, PREPARA, VN);
    cyc(0, 0, 0, 0, 0, ESPERA, VN);
    for (int k = 0; k < 15; k++) move(0, k == 14, k == 14 ? VITORIA : ESPERA, VN);
    cyc(0, 0, 1, 1, 0, VITORIA, VN);
    cyc(0, 0, 0, 0, 0, VITORIA, VN);
    cyc(0, 1, 0, 0, 0, PREPARA, VN);
    cyc(0, 0, 0, 0, 0, ESPERA, VN);
`ifdef VIDAS_EN
    move(1, 0, PERDE_VIDA, 2'd3);
    cyc(0, 0, 0, 0, 0, ESPERA, 2'd2);
    move(0, 0, ESPERA, 2'd2);
    move(1, 1, PERDE_VIDA, 2'd2);
    cyc(0, 0, 0, 0, 0, ESPERA, 2'd1);
    move(1, 0, PERDE_VIDA, 2'd1);
    cyc(0, 0, 0, 0, 0, DERROTA, 2'd0);
`endif
    cyc(1, 0, 0, 0, 0, INICIAL, VN);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
